// File: rtl/fp_log2_pkg.sv
// rtl/fp_log2_pkg.sv - shared types and constants for the sequential log2 unit
// No ports: FSM state enum, operand classes, IEEE-754 constants, operand classifier.
package fp_log2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_PACK,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_NEG,
    CLS_INF,
    CLS_NAN
  } op_class_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam int          BIAS    = 127;
  localparam int          FRAC_W  = 23;

  // Order matters: NaN beats sign, and a negative denormal is flushed to
  // zero before the sign is looked at, so it yields -inf rather than NaN.
  function automatic op_class_t classify(input logic [31:0] a);
    op_class_t cls;
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) begin
      cls = CLS_NAN;
    end else if (a[30:23] == 8'h00) begin
      cls = CLS_ZERO;
    end else if (a[31]) begin
      cls = CLS_NEG;
    end else if (a[30:23] == 8'hFF) begin
      cls = CLS_INF;
    end else begin
      cls = CLS_NORMAL;
    end
    return cls;
  endfunction

  function automatic logic [31:0] special_result(input op_class_t cls);
    logic [31:0] r;
    case (cls)
      CLS_ZERO: r = NEG_INF;
      CLS_INF:  r = POS_INF;
      default:  r = QNAN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fp_lod32.sv
// rtl/fp_lod32.sv - combinational 32-bit leading-one detector
// value : word to scan
// pos   : bit index of the most significant set bit (0 when value is zero)
// valid : value has at least one set bit
module fp_lod32 (
  input  logic [31:0] value,
  output logic [4:0]  pos,
  output logic        valid
);

  always_comb begin
    pos   = 5'd0;
    valid = |value;
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < 32; i++) begin
      if (value[i]) begin
        pos = 5'(i);
      end
    end
  end

endmodule

// File: rtl/fp_log2_seq.sv
// rtl/fp_log2_seq.sv - sequential IEEE-754 single log2, one fraction bit per clock
// clk    : rising-edge clock
// rst    : asynchronous active-high reset
// start  : request, sampled only in IDLE
// a_in   : IEEE-754 single operand, captured on the accepting edge
// busy   : high while iterating/packing a normal operand
// done   : one-cycle pulse, result valid while high
// result : IEEE-754 single log2(a_in), held until the next accepted start
module fp_log2_seq
  import fp_log2_pkg::*;
#(
  parameter int ITER = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [4:0] LAST_ITER = 5'(ITER - 1);
  // Fewer iterations leave the fraction bits low in f; realign to Q.24.
  localparam int         F_SHIFT   = 24 - ITER;
  localparam logic [7:0] EXP_OFF   = 8'(BIAS - 24);

  state_t            state;
  state_t            state_d;
  logic [4:0]        cnt;
  logic [23:0]       m;
  logic signed [7:0] e;
  logic [23:0]       f;
  logic              busy_d;
  logic              done_d;

  op_class_t         cls;
  logic [47:0]       p;
  logic [23:0]       m_next;
  logic [23:0]       f_al;
  logic [31:0]       v;
  logic [31:0]       mag;
  logic [31:0]       norm;
  logic [4:0]        lead_pos;
  logic              lead_valid;
  logic [31:0]       pack_res;

  assign cls = classify(a_in);

  // Squaring step: m in [1,2) so m*m is in [1,4). A set top bit means the
  // square reached [2,4): emit a 1 and halve, otherwise emit 0 and keep.
  assign p      = 48'(m) * 48'(m);
  assign m_next = p[47] ? 24'(p >> 24) : 24'(p >> 23);

  // Pack the Q8.24 two's-complement value into a float, truncating.
  assign f_al = f << F_SHIFT;
  assign v    = {e, 24'd0} + {8'd0, f_al};
  assign mag  = v[31] ? (~v + 32'd1) : v;

  fp_lod32 u_lod (
    .value (mag),
    .pos   (lead_pos),
    .valid (lead_valid)
  );

  assign norm = mag << (5'd31 - lead_pos);

  always_comb begin
    pack_res = 32'd0;
    if (lead_valid) begin
      pack_res = {v[31], EXP_OFF + {3'd0, lead_pos}, FRAC_W'(norm >> 8)};
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = (cls == CLS_NORMAL) ? ST_ITER : ST_DONE;
        end
      end
      ST_ITER: begin
        if (cnt == LAST_ITER) begin
          state_d = ST_PACK;
        end
      end
      ST_PACK: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered
  // and still line up with the state they describe.
  always_comb begin
    busy_d = (state_d == ST_ITER) || (state_d == ST_PACK);
    done_d = (state_d == ST_DONE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 5'd0;
      m      <= 24'd0;
      e      <= 8'sd0;
      f      <= 24'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cls == CLS_NORMAL) begin
              m   <= {1'b1, a_in[22:0]};
              e   <= a_in[30:23] - 8'(BIAS);
              f   <= 24'd0;
              cnt <= 5'd0;
            end else begin
              result <= special_result(cls);
            end
          end
        end
        ST_ITER: begin
          m   <= m_next;
          f   <= {f[22:0], p[47]};
          cnt <= cnt + 5'd1;
        end
        ST_PACK: begin
          result <= pack_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_log2_seq.md
# fp_log2_seq

Sequential IEEE-754 single-precision base-2 logarithm unit: result = log2(a_in). It is the inverse companion of the combinational power unit, and the path by which nth-root and power results are decomposed back to exponent form. The unit computes one fraction bit per clock by repeated mantissa squaring, then normalises a Q8.24 fixed-point value back to float. A start/done handshake lets it sit beside the power and nth-root blocks in the floating-point datapath.

## Interface
- ITER, default 24: number of fraction bits produced (one per cycle).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  32  IEEE-754 single operand; captured on the accepting edge.
- busy  out  1  high from the accepting edge until done.
- done  out  1  one-cycle pulse; result is valid while high.
- result  out  32  IEEE-754 single; holds its value until the next accepted start.

## Operation
- **Decode.** The accepting edge classifies a_in:
  - NaN -> 0x7FC00000.
  - Negative non-zero, including -inf -> 0x7FC00000.
  - ±0 or denormal (flushed to zero) -> 0xFF800000.
  - +inf -> 0x7F800000.
  - Special cases go directly to DONE.
- **Normal path.**
  - e = exp - 127, signed 8-bit (range -126..127).
  - m = {1, frac}, Q1.23 in [1, 2).
- **ITER state**, ITER cycles. Each cycle:
  - p = m*m, 48 bits, Q2.46.
  - If p[47] is set: fraction bit = 1, m = p[47:24].
  - Otherwise: fraction bit = 0, m = p[46:23].
  - Extra product bits are truncated.
  - Fraction bits shift in MSB-first into f[23:0].
- **PACK state**, 1 cycle:
  - v = {e, 24'b0} + f, as a 32-bit two's-complement Q8.24 value.
  - v == 0 -> +0 (0x00000000).
  - Otherwise: sign = v[31], mag = |v|. Leading-one position L (0..31) from fp_lod32.
  - exponent = 127 + L - 24; mantissa = the 23 bits below the leading one, left-aligned and truncated (round toward zero).
- **Exactness.** Powers of two give exactly e, because m stays 1.0 and f = 0.
- **Accuracy.** For normal inputs, |result - log2(a)| ≤ max(4 ulp of result, 2^-21).
- **FSM.** States are IDLE, ITER, PACK, DONE.
  - IDLE -> ITER: start with a normal operand.
  - IDLE -> DONE: start with a special operand.
  - ITER -> PACK: after ITER iterations, tracked by a 5-bit counter.
  - PACK -> DONE.
  - DONE -> IDLE: unconditional.
- **Start while busy** (any state other than IDLE) is ignored; it is not queued.
- **Reset.** Asserting rst at any time, including mid-ITER:
  - Returns the FSM to IDLE and clears the counter.
  - result = 0x00000000, done = 0, busy = 0.
  - Any partial computation is discarded.

## Timing
- Accepting edge k: start = 1 in IDLE.
- **Normal operand.**
  - Iterations occur on edges k+1 .. k+ITER.
  - PACK writes result on edge k+ITER+1 (k+25 at the default).
  - done is high for exactly the one cycle following that edge.
  - busy is high from after edge k until the same edge that raises done.
- **Special operand.** result and done are written on edge k itself; done is high for one cycle and busy is never asserted.
- **Back-to-back.** A start can be accepted no earlier than the cycle after done falls: DONE -> IDLE takes one edge, so the minimum spacing between accepting edges is ITER+3 edges.
- **Stability.** result changes only on the edge that raises done, or on reset.
- **Outputs.** All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package fp_log2_pkg holds:
  - the state enum (IDLE, ITER, PACK, DONE);
  - constants QNAN = 0x7FC00000, NEG_INF = 0xFF800000, POS_INF = 0x7F800000, BIAS = 127, FRAC_W = 23;
  - the operand-class encoding (NORMAL, ZERO, NEG, INF, NAN).
- Sub-module fp_lod32 is a combinational 32-bit leading-one detector: it outputs a 5-bit position and a valid flag. It is reusable by the power and nth-root normalisers.
- The squaring multiplier stays inline as a single 24x24 multiply.

## Test plan
- a_in = 0x41000000 (8.0) -> done after 25 edges, result = 0x40400000 (3.0), exact.
- a_in = 0x3F800000 (1.0) -> result = 0x00000000. a_in = 0x3F000000 (0.5) -> result = 0xBF800000 (-1.0), exact.
- a_in = 0x447A0000 (1000.0) -> result ≈ 9.965784 (0x411F73xx), within 4 ulp. a_in = 0x3EC00000 (0.375) -> ≈ -1.415037 (0xBFB51xxx), within 4 ulp.
- Specials, each with done on the accepting edge and busy never high:
  - 0xC0000000 -> 0x7FC00000.
  - 0x00000000 -> 0xFF800000.
  - 0x7F800000 -> 0x7F800000.
  - 0x7FC00001 -> 0x7FC00000.
- Start pulsed again at iteration 10 with a different a_in -> ignored; the first result is delivered on schedule and unchanged.
- rst asserted at iteration 12 -> busy/done/result go to 0 immediately. A new start 2 cycles after rst releases (a_in = 0x40800000, 4.0) -> result 0x40000000 (2.0).
